// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special-value constants, operand classes and
// the records carried between the adder pipeline stages.
package fp32_pkg;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam logic [31:0] NEG_INF = 32'hFF800000;

   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

   typedef struct packed {
      logic             special;
      logic [31:0]      special_val;
      logic             sign;
      logic [EXP_W-1:0] exp_l;
      logic [MAN_W:0]   man_l;
      logic [MAN_W:0]   man_s;
      logic [EXP_W-1:0] diff;
      logic             eff_sub;
   } s1_t;

   typedef struct packed {
      logic             special;
      logic [31:0]      special_val;
      logic             sign;
      logic [EXP_W-1:0] exp_l;
      logic [27:0]      sum;
   } s2_t;

   // Subnormals (exponent 0) classify as zero: the adder flushes them.
   function automatic fp_class_e fp_classify(input logic [30:0] x);
      if (x[30:23] == '0) return CLS_ZERO;
      if (x[30:23] != '1) return CLS_NORM;
      return (x[22:0] == '0) ? CLS_INF : CLS_NAN;
   endfunction
endpackage

// File: rtl/fp_add_pipe_if.sv
// Operand/result bundle of the pipelined binary32 adder.
interface fp_add_pipe_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] q;

   modport master (output a, output b, input q);
   modport slave  (input a, input b, output q);
endinterface

// File: rtl/fp_lzc28.sv
// Leading-zero count of the 28-bit mantissa sum; all-zero input reports 28.
module fp_lzc28 (
   input  logic [27:0] i_val,
   output logic [4:0]  o_cnt
);
   always_comb begin
      o_cnt = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (i_val[i]) o_cnt = 5'(27 - i);
      end
   end
endmodule

// File: rtl/fp_add_pipe.sv
// Fully pipelined binary32 adder: input register, unpack/compare, align/add,
// normalise/round/pack. Operands sampled at edge N appear on q at edge N+3.
module fp_add_pipe
   import fp32_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   fp_add_pipe_if.slave io
);
   logic [31:0] r_a, r_b, r_q;
   s1_t         r_s1, w_s1;
   s2_t         r_s2, w_s2;
   logic [31:0] w_q;

   fp_class_e   w_cls_a, w_cls_b;
   logic        w_swap;
   logic [31:0] w_l, w_s;

   always_comb begin
      w_cls_a = fp_classify(r_a[30:0]);
      w_cls_b = fp_classify(r_b[30:0]);
      w_swap  = r_b[30:0] > r_a[30:0];
      w_l     = w_swap ? r_b : r_a;
      w_s     = w_swap ? r_a : r_b;

      w_s1             = '0;
      w_s1.sign        = w_l[31];
      w_s1.exp_l       = w_l[30:23];
      w_s1.man_l       = {1'b1, w_l[22:0]};
      w_s1.man_s       = {1'b1, w_s[22:0]};
      w_s1.diff        = w_l[30:23] - w_s[30:23];
      w_s1.eff_sub     = r_a[31] ^ r_b[31];
      w_s1.special     = 1'b1;
      // Special results are resolved here and ride the pipe so latency is uniform.
      if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN)
         w_s1.special_val = QNAN;
      else if (w_cls_a == CLS_INF && w_cls_b == CLS_INF)
         w_s1.special_val = (r_a[31] ^ r_b[31]) ? QNAN : r_a;
      else if (w_cls_a == CLS_INF)
         w_s1.special_val = r_a;
      else if (w_cls_b == CLS_INF)
         w_s1.special_val = r_b;
      else if (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO)
         w_s1.special_val = {r_a[31] & r_b[31], 31'b0};
      else if (w_cls_a == CLS_ZERO)
         w_s1.special_val = r_b;
      else if (w_cls_b == CLS_ZERO)
         w_s1.special_val = r_a;
      else
         w_s1.special = 1'b0;
   end

   logic [53:0] w_wide;
   logic [26:0] w_al;

   always_comb begin
      w_wide = {r_s1.man_s, 30'b0} >> r_s1.diff;
      w_al   = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
      if (r_s1.diff >= 8'd27) w_al = 27'd1;

      w_s2             = '0;
      w_s2.special     = r_s1.special;
      w_s2.special_val = r_s1.special_val;
      w_s2.sign        = r_s1.sign;
      w_s2.exp_l       = r_s1.exp_l;
      w_s2.sum         = r_s1.eff_sub ? ({1'b0, r_s1.man_l, 3'b0} - {1'b0, w_al})
                                      : ({1'b0, r_s1.man_l, 3'b0} + {1'b0, w_al});
   end

   logic [4:0]        w_lzc;
   logic [27:0]       w_shl;
   logic [26:0]       w_norm;
   logic signed [9:0] w_exp, w_exp_r;
   logic              w_up;
   logic [24:0]       w_rnd;
   logic [22:0]       w_man;

   fp_lzc28 u_lzc (.i_val(r_s2.sum), .o_cnt(w_lzc));

   always_comb begin
      w_shl = r_s2.sum << (w_lzc - 5'd1);
      if (r_s2.sum[27]) begin
         w_norm = {r_s2.sum[27:2], r_s2.sum[1] | r_s2.sum[0]};
         w_exp  = $signed({2'b00, r_s2.exp_l}) + 10'sd1;
      end else begin
         w_norm = w_shl[26:0];
         w_exp  = $signed({2'b00, r_s2.exp_l}) - $signed({5'b0, w_lzc}) + 10'sd1;
      end
      // Round to nearest, ties to even, on guard/round/sticky.
      w_up    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_rnd   = {1'b0, w_norm[26:3]} + {24'b0, w_up};
      w_man   = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
      w_exp_r = w_rnd[24] ? (w_exp + 10'sd1) : w_exp;

      if (r_s2.special)
         w_q = r_s2.special_val;
      else if (r_s2.sum == '0)
         w_q = 32'h0;
      else if (w_exp_r >= 10'(EXP_MAX))
         w_q = r_s2.sign ? NEG_INF : POS_INF;
      else if (w_exp_r <= 10'sd0)
         w_q = {r_s2.sign, 31'b0};
      else
         w_q = {r_s2.sign, w_exp_r[7:0], w_man};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a  <= '0;
         r_b  <= '0;
         r_s1 <= '0;
         r_s2 <= '0;
         r_q  <= '0;
      end else begin
         r_a  <= io.a;
         r_b  <= io.b;
         r_s1 <= w_s1;
         r_s2 <= w_s2;
         r_q  <= w_q;
      end
   end

   assign io.q = r_q;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: expected sums queued at drive time,
// compared when they reach q three edges later.
module tb_fp_add_pipe;
   import fp32_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   fp_add_pipe_if io();

   fp_add_pipe dut (.clk(clk), .reset(reset), .io(io));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_val[$];
   bit          sb_chk[$];
   string       sb_tag[$];

   function automatic real to_real(input logic [31:0] x);
      logic [10:0] e11;
      e11 = 11'(int'(x[30:23]) - EXP_BIAS + 1023);
      return $bitstoreal({x[31], e11, x[22:0], 29'b0});
   endfunction

   // Sum in double (exact enough for one correct rounding), then round to binary32.
   function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] bits;
      logic [52:0] m;
      logic [24:0] k;
      logic [28:0] rem;
      int          e;
      bit za, zb, ia, ib, na, nb;
      real d;
      za = (a[30:23] == 8'h00);
      zb = (b[30:23] == 8'h00);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
      if (na || nb) return 32'h7FC00000;
      if (ia && ib) return (a[31] != b[31]) ? 32'h7FC00000 : a;
      if (ia) return a;
      if (ib) return b;
      if (za && zb) return {a[31] & b[31], 31'b0};
      if (za) return b;
      if (zb) return a;
      d = to_real(a) + to_real(b);
      if (d == 0.0) return 32'h0;
      bits = $realtobits(d);
      e    = int'(bits[62:52]) - 1023 + 127;
      m    = {1'b1, bits[51:0]};
      k    = {1'b0, m[52:29]};
      rem  = m[28:0];
      if (rem > 29'h10000000 || (rem == 29'h10000000 && k[0])) k = k + 25'd1;
      if (k[24]) begin
         k = k >> 1;
         e = e + 1;
      end
      if (e >= 255) return {bits[63], 8'hFF, 23'h0};
      if (e <= 0) return {bits[63], 31'b0};
      return {bits[63], 8'(e), k[22:0]};
   endfunction

   function automatic logic [31:0] rnd_f32();
      logic [31:0] x;
      x[31]    = 1'($urandom_range(0, 1));
      x[30:23] = 8'($urandom_range(64, 190));
      x[22:0]  = 23'($urandom);
      if ($urandom_range(0, 15) == 0) x = 32'h0;
      return x;
   endfunction

   task automatic step(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input bit chk, input string tag);
      io.a = a;
      io.b = b;
      sb_val.push_back(exp_q);
      sb_chk.push_back(chk);
      sb_tag.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic prefill_flushed();
      sb_val.delete();
      sb_chk.delete();
      sb_tag.delete();
      for (int i = 0; i < 3; i++) begin
         sb_val.push_back(32'h0);
         sb_chk.push_back(1'b1);
         sb_tag.push_back("post_reset_zero");
      end
   endtask

   task automatic test_reset();
      logic [31:0] v; bit c; string t;
      reset = 1'b1;
      io.a  = 32'h3F800000;
      io.b  = 32'h40000000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (io.q !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: q=%h expected %h", io.q, 32'h0);
         end
      end
      prefill_flushed();
      reset = 1'b0;
      step(32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, "first_after_reset");
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step(32'h0, 32'h0, 32'h0, 1'b0, "idle");
         if (sb_val.size() > 3) begin
            v = sb_val.pop_front(); c = sb_chk.pop_front(); t = sb_tag.pop_front();
            if (c) begin
               checks++;
               if (io.q !== v) begin
                  errors++;
                  $display("FAIL %s: q=%h expected %h", t, io.q, v);
               end
            end
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] v; bit c; string t;
      logic [31:0] ta[15], tb[15], tq[15];
      ta = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h00000000,
             32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000,
             32'h7FC00001, 32'h00000001, 32'h7F800000, 32'hFF800000, 32'h40490FDB};
      tb = '{32'h40000000, 32'hBF800000, 32'h80000000, 32'h80000000, 32'hC0490FDB,
             32'h33800000, 32'h33800001, 32'h33800000, 32'h7F7FFFFF, 32'hFF800000,
             32'h3F800000, 32'h00000000, 32'hC2C80000, 32'hFF800000, 32'h00400000};
      tq = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h00000000, 32'hC0490FDB,
             32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
             32'h7FC00000, 32'h00000000, 32'h7F800000, 32'hFF800000, 32'h40490FDB};
      for (int i = 0; i < 15; i++) begin
         step(ta[i], tb[i], tq[i], 1'b1, $sformatf("directed_%0d", i));
         if (sb_val.size() > 3) begin
            v = sb_val.pop_front(); c = sb_chk.pop_front(); t = sb_tag.pop_front();
            if (c) begin
               checks++;
               if (io.q !== v) begin
                  errors++;
                  $display("FAIL %s: q=%h expected %h", t, io.q, v);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v, a, b; bit c; string t;
      for (int i = 0; i < 50; i++) begin
         a = rnd_f32();
         b = rnd_f32();
         if (i % 5 == 0) b = {~a[31], a[30:3], 3'($urandom_range(0, 7))};
         step(a, b, fp_ref(a, b), 1'b1, $sformatf("random_%0d", i));
         if (sb_val.size() > 3) begin
            v = sb_val.pop_front(); c = sb_chk.pop_front(); t = sb_tag.pop_front();
            if (c) begin
               checks++;
               if (io.q !== v) begin
                  errors++;
                  $display("FAIL %s: q=%h expected %h", t, io.q, v);
               end
            end
         end
      end
   endtask

   task automatic test_accumulate();
      logic [31:0] v, acc_dut, acc_m; bit c; string t;
      acc_dut = 32'h0;
      acc_m   = 32'h0;
      for (int n = 0; n < 50; n++) begin
         acc_m = fp_ref(acc_m, 32'h3F800000);
         for (int k = 0; k < 4; k++) begin
            if (k == 0) step(acc_dut, 32'h3F800000, acc_m, 1'b1, $sformatf("accum_%0d", n));
            else        step(32'h0, 32'h0, 32'h0, 1'b0, "idle");
            if (sb_val.size() > 3) begin
               v = sb_val.pop_front(); c = sb_chk.pop_front(); t = sb_tag.pop_front();
               if (c) begin
                  checks++;
                  if (io.q !== v) begin
                     errors++;
                     $display("FAIL %s: q=%h expected %h", t, io.q, v);
                  end
               end
            end
         end
         acc_dut = io.q;
      end
      checks++;
      if (acc_dut !== 32'h42480000) begin
         errors++;
         $display("FAIL accum_final: q=%h expected %h", acc_dut, 32'h42480000);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v, a, b; bit c; string t;
      for (int i = 0; i < 3; i++) begin
         a = rnd_f32();
         b = rnd_f32();
         step(a, b, fp_ref(a, b), 1'b1, "pre_reset");
         if (sb_val.size() > 3) begin
            v = sb_val.pop_front(); c = sb_chk.pop_front(); t = sb_tag.pop_front();
            if (c) begin
               checks++;
               if (io.q !== v) begin
                  errors++;
                  $display("FAIL %s: q=%h expected %h", t, io.q, v);
               end
            end
         end
      end
      reset = 1'b1;
      io.a  = 32'h40A00000;
      io.b  = 32'h40A00000;
      @(posedge clk);
      #1;
      checks++;
      if (io.q !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_q: q=%h expected %h", io.q, 32'h0);
      end
      prefill_flushed();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      step(32'h40000000, 32'h40400000, 32'h40A00000, 1'b1, "first_after_mid_reset");
         else if (i == 1) step(32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b1, "second_after_mid_reset");
         else             step(32'h0, 32'h0, 32'h0, 1'b0, "idle");
         if (sb_val.size() > 3) begin
            v = sb_val.pop_front(); c = sb_chk.pop_front(); t = sb_tag.pop_front();
            if (c) begin
               checks++;
               if (io.q !== v) begin
                  errors++;
                  $display("FAIL %s: q=%h expected %h", t, io.q, v);
               end
            end
         end
      end
   endtask

   initial begin
      io.a = 32'h0;
      io.b = 32'h0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_accumulate();
      test_reset_mid();
      if (sb_chk.size() != 3) begin
         errors++;
         $display("FAIL scoreboard_depth: entries=%0d expected %0d", sb_chk.size(), 3);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
